// File: rtl/waves_pkg.sv
// rtl/waves_pkg.sv - shared encodings, command bytes and controller states for the waves command path
package waves_pkg;

  typedef enum logic [2:0] {
    WAVE_TRI = 3'd0,
    WAVE_SAW = 3'd1,
    WAVE_SQR = 3'd2,
    WAVE_SIN = 3'd3,
    WAVE_ECG = 3'd4
  } wave_sel_t;

  localparam logic [7:0] CMD_TRI       = 8'h54;
  localparam logic [7:0] CMD_SAW       = 8'h57;
  localparam logic [7:0] CMD_SQR       = 8'h51;
  localparam logic [7:0] CMD_SIN       = 8'h53;
  localparam logic [7:0] CMD_ECG       = 8'h45;
  localparam logic [7:0] CMD_NOISE_ON  = 8'h4E;
  localparam logic [7:0] CMD_NOISE_OFF = 8'h46;
  localparam logic [7:0] CMD_FREQ      = 8'h44;
  localparam logic [7:0] CMD_CR        = 8'h0D;
  localparam logic [7:0] CMD_LF        = 8'h0A;

  localparam logic [7:0] ACK_BYTE = 8'h4B;
  localparam logic [7:0] NAK_BYTE = 8'h3F;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_FREQ_HI = 2'd1,
    ST_FREQ_LO = 2'd2,
    ST_ACK     = 2'd3
  } cmd_state_t;

  function automatic wave_sel_t wave_of_cmd(input logic [7:0] b);
    wave_sel_t w;
    case (b)
      CMD_SAW: w = WAVE_SAW;
      CMD_SQR: w = WAVE_SQR;
      CMD_SIN: w = WAVE_SIN;
      CMD_ECG: w = WAVE_ECG;
      default: w = WAVE_TRI;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/wave_cmd_timeout.sv
// rtl/wave_cmd_timeout.sv - loadable/clearable down-counter with an expiry strobe for inter-byte timeouts
module wave_cmd_timeout #(
  parameter int TIMEOUT_CYCLES = 52084
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_load,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOAD_VAL = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] r_cnt;

  // A fresh byte reloads, so expiry lands TIMEOUT_CYCLES edges after the last byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= LOAD_VAL;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

  assign o_expired = i_en && !i_load && (r_cnt == '0);

endmodule

// File: rtl/wave_cmd_ctrl.sv
// rtl/wave_cmd_ctrl.sv - UART command parser and waveform config registers; WAVE_CMD_ECHO_EN adds ACK/NAK echo
module wave_cmd_ctrl #(
  parameter int          TIMEOUT_CYCLES = 52084,
  parameter logic [15:0] FREQ_RESET     = 16'h0400
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic [2:0]  o_wave_sel,
  output logic        o_noise_en,
  output logic [15:0] o_freq_word,
  output logic        o_cfg_update,
  output logic        o_busy,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic        o_overrun
);

  import waves_pkg::*;

  cmd_state_t  r_state;
  cmd_state_t  w_next_state;
  wave_sel_t   r_wave_sel;
  wave_sel_t   w_wave_val;
  logic        r_noise_en;
  logic [15:0] r_freq_word;
  logic [7:0]  r_freq_hi;
  logic        r_cfg_update;
  logic        r_busy;

  logic        w_byte_valid;
  logic [7:0]  w_byte;
  logic        w_expired;
  logic        w_set_wave;
  logic        w_set_noise;
  logic        w_noise_val;
  logic        w_latch_hi;
  logic        w_set_freq;
  logic        w_send_ack;
  logic [7:0]  w_ack_byte;

`ifdef WAVE_CMD_ECHO_EN
  logic        r_pend_valid;
  logic [7:0]  r_pend_data;
  logic        r_tx_valid;
  logic [7:0]  r_tx_data;
  logic        r_overrun;
  logic        w_handshake;

  // Outside ACK a buffered byte takes precedence; a same-cycle rx byte refills the slot.
  assign w_byte_valid = (r_state != ST_ACK) && (r_pend_valid || i_rx_valid);
  assign w_byte       = r_pend_valid ? r_pend_data : i_rx_data;
  assign w_handshake  = r_tx_valid && i_tx_ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_valid <= 1'b0;
      r_pend_data  <= '0;
      r_overrun    <= 1'b0;
    end else if (r_state == ST_ACK) begin
      if (i_rx_valid) begin
        if (!r_pend_valid) begin
          r_pend_valid <= 1'b1;
          r_pend_data  <= i_rx_data;
        end else begin
          r_overrun <= 1'b1;
        end
      end
    end else if (r_pend_valid) begin
      r_pend_valid <= i_rx_valid;
      if (i_rx_valid) begin
        r_pend_data <= i_rx_data;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tx_valid <= 1'b0;
      r_tx_data  <= '0;
    end else begin
      if (w_send_ack) begin
        r_tx_data <= w_ack_byte;
      end
      if (w_handshake) begin
        r_tx_valid <= 1'b0;
      end else if (r_state == ST_ACK) begin
        r_tx_valid <= 1'b1;
      end
    end
  end

  assign o_tx_valid = r_tx_valid;
  assign o_tx_data  = r_tx_data;
  assign o_overrun  = r_overrun;
`else
  logic [8:0] w_unused_echo;

  assign w_byte_valid  = i_rx_valid;
  assign w_byte        = i_rx_data;
  assign w_unused_echo = {i_tx_ready, w_ack_byte};
  assign o_tx_valid    = 1'b0;
  assign o_tx_data     = 8'h00;
  assign o_overrun     = 1'b0;
`endif

  wave_cmd_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_byte_valid),
    .i_clr     ((r_state == ST_IDLE) || (r_state == ST_ACK)),
    .i_en      ((r_state == ST_FREQ_HI) || (r_state == ST_FREQ_LO)),
    .o_expired (w_expired)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_busy  <= (w_next_state != ST_IDLE);
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_set_wave   = 1'b0;
    w_wave_val   = WAVE_TRI;
    w_set_noise  = 1'b0;
    w_noise_val  = 1'b0;
    w_latch_hi   = 1'b0;
    w_set_freq   = 1'b0;
    w_send_ack   = 1'b0;
    w_ack_byte   = ACK_BYTE;
    case (r_state)
      ST_IDLE: begin
        if (w_byte_valid) begin
          case (w_byte)
            CMD_TRI, CMD_SAW, CMD_SQR, CMD_SIN, CMD_ECG: begin
              w_set_wave = 1'b1;
              w_wave_val = wave_of_cmd(w_byte);
              w_send_ack = 1'b1;
            end
            CMD_NOISE_ON: begin
              w_set_noise = 1'b1;
              w_noise_val = 1'b1;
              w_send_ack  = 1'b1;
            end
            CMD_NOISE_OFF: begin
              w_set_noise = 1'b1;
              w_send_ack  = 1'b1;
            end
            CMD_FREQ: w_next_state = ST_FREQ_HI;
            CMD_CR, CMD_LF: w_next_state = ST_IDLE;
            default: begin
              w_send_ack = 1'b1;
              w_ack_byte = NAK_BYTE;
            end
          endcase
        end
      end
      ST_FREQ_HI: begin
        if (w_byte_valid) begin
          w_latch_hi   = 1'b1;
          w_next_state = ST_FREQ_LO;
        end else if (w_expired) begin
          w_send_ack   = 1'b1;
          w_ack_byte   = NAK_BYTE;
          w_next_state = ST_IDLE;
        end
      end
      ST_FREQ_LO: begin
        if (w_byte_valid) begin
          w_set_freq = 1'b1;
          w_send_ack = 1'b1;
        end else if (w_expired) begin
          w_send_ack   = 1'b1;
          w_ack_byte   = NAK_BYTE;
          w_next_state = ST_IDLE;
        end
      end
      ST_ACK: begin
`ifdef WAVE_CMD_ECHO_EN
        if (w_handshake) begin
          w_next_state = ST_IDLE;
        end
`else
        w_next_state = ST_IDLE;
`endif
      end
      default: w_next_state = ST_IDLE;
    endcase
`ifdef WAVE_CMD_ECHO_EN
    if (w_send_ack) begin
      w_next_state = ST_ACK;
    end
`else
    if (w_send_ack) begin
      w_next_state = ST_IDLE;
    end
`endif
  end

  // The high byte lives in r_freq_hi so freq_word only ever changes as a whole word.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wave_sel   <= WAVE_TRI;
      r_noise_en   <= 1'b0;
      r_freq_word  <= FREQ_RESET;
      r_freq_hi    <= '0;
      r_cfg_update <= 1'b0;
    end else begin
      r_cfg_update <= w_set_wave || w_set_noise || w_set_freq;
      if (w_set_wave) begin
        r_wave_sel <= w_wave_val;
      end
      if (w_set_noise) begin
        r_noise_en <= w_noise_val;
      end
      if (w_latch_hi) begin
        r_freq_hi <= w_byte;
      end
      if (w_set_freq) begin
        r_freq_word <= {r_freq_hi, w_byte};
      end
    end
  end

  assign o_wave_sel   = r_wave_sel;
  assign o_noise_en   = r_noise_en;
  assign o_freq_word  = r_freq_word;
  assign o_cfg_update = r_cfg_update;
  assign o_busy       = r_busy;

endmodule

// File: tb/tb_wave_cmd_ctrl.sv
// tb/tb_wave_cmd_ctrl.sv - directed self-checking bench for wave_cmd_ctrl (default and WAVE_CMD_ECHO_EN builds)
module tb_wave_cmd_ctrl;

  localparam int TMO = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        tx_ready = 1'b1;
  logic [2:0]  wave_sel;
  logic        noise_en;
  logic [15:0] freq_word;
  logic        cfg_update;
  logic        busy;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] wave_cmds [5];
  logic [2:0] wave_exp  [5];

  always #5 clk = ~clk;

  wave_cmd_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .FREQ_RESET    (16'h0400)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_rx_valid   (rx_valid),
    .i_rx_data    (rx_data),
    .o_wave_sel   (wave_sel),
    .o_noise_en   (noise_en),
    .o_freq_word  (freq_word),
    .o_cfg_update (cfg_update),
    .o_busy       (busy),
    .o_tx_valid   (tx_valid),
    .o_tx_data    (tx_data),
    .i_tx_ready   (tx_ready),
    .o_overrun    (overrun)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({wave_sel, noise_en, freq_word} !== {3'b000, 1'b0, 16'h0400}) begin
      errors++;
      $display("FAIL reset_cfg: got %b/%b/%h expected 000/0/0400", wave_sel, noise_en, freq_word);
    end
    checks++;
    if ({cfg_update, busy, tx_valid, tx_data, overrun} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ctl: got cfg=%b busy=%b txv=%b txd=%h ovr=%b expected all 0", cfg_update, busy, tx_valid, tx_data, overrun);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_wave_select();
    wave_cmds[0] = 8'h54; wave_exp[0] = 3'b000;
    wave_cmds[1] = 8'h53; wave_exp[1] = 3'b011;
    wave_cmds[2] = 8'h45; wave_exp[2] = 3'b100;
    wave_cmds[3] = 8'h57; wave_exp[3] = 3'b001;
    wave_cmds[4] = 8'h51; wave_exp[4] = 3'b010;
    for (int i = 0; i < 5; i++) begin
      send_byte(wave_cmds[i]);
      checks++;
      if ({wave_sel, cfg_update} !== {wave_exp[i], 1'b1}) begin
        errors++;
        $display("FAIL wave_apply[%0d]: got sel=%b upd=%b expected sel=%b upd=1", i, wave_sel, cfg_update, wave_exp[i]);
      end
      step();
      checks++;
      if (cfg_update !== 1'b0) begin
        errors++;
        $display("FAIL wave_pulse_len[%0d]: got upd=%b expected 0", i, cfg_update);
      end
`ifdef WAVE_CMD_ECHO_EN
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) begin
        errors++;
        $display("FAIL wave_ack[%0d]: got txv=%b txd=%h expected 1/4b", i, tx_valid, tx_data);
      end
      step();
`endif
      checks++;
      if ({tx_valid, busy} !== 2'b00) begin
        errors++;
        $display("FAIL wave_idle[%0d]: got txv=%b busy=%b expected 0/0", i, tx_valid, busy);
      end
    end
    checks++;
    if ({noise_en, freq_word} !== {1'b0, 16'h0400}) begin
      errors++;
      $display("FAIL wave_side_effect: got noise=%b freq=%h expected 0/0400", noise_en, freq_word);
    end
  endtask

  task automatic test_noise();
    for (int i = 0; i < 2; i++) begin
      send_byte(i == 0 ? 8'h4E : 8'h46);
      checks++;
      if ({noise_en, cfg_update} !== {(i == 0), 1'b1}) begin
        errors++;
        $display("FAIL noise_apply[%0d]: got noise=%b upd=%b expected %0d/1", i, noise_en, cfg_update, (i == 0));
      end
      step();
`ifdef WAVE_CMD_ECHO_EN
      checks++;
      if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) begin
        errors++;
        $display("FAIL noise_ack[%0d]: got txv=%b txd=%h expected 1/4b", i, tx_valid, tx_data);
      end
      step();
`endif
    end
  endtask

  task automatic test_freq();
    send_byte(8'h44);
    checks++;
    if ({busy, cfg_update} !== 2'b10) begin
      errors++;
      $display("FAIL freq_cmd: got busy=%b upd=%b expected 1/0", busy, cfg_update);
    end
    send_byte(8'h12);
    checks++;
    if ({freq_word, cfg_update, busy} !== {16'h0400, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL freq_hi_hidden: got freq=%h upd=%b busy=%b expected 0400/0/1", freq_word, cfg_update, busy);
    end
    send_byte(8'h34);
    checks++;
    if ({freq_word, cfg_update} !== {16'h1234, 1'b1}) begin
      errors++;
      $display("FAIL freq_load: got freq=%h upd=%b expected 1234/1", freq_word, cfg_update);
    end
    step();
`ifdef WAVE_CMD_ECHO_EN
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) begin
      errors++;
      $display("FAIL freq_ack: got txv=%b txd=%h expected 1/4b", tx_valid, tx_data);
    end
    step();
`endif
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL freq_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_timeout();
    int   k;
    logic saw_upd;
    int   exp_k;
    send_byte(8'h44);
    send_byte(8'h56);
    k = 0;
    saw_upd = 1'b0;
`ifdef WAVE_CMD_ECHO_EN
    exp_k = TMO + 1;
    while (tx_valid !== 1'b1 && k < 4 * TMO) begin
      step();
      saw_upd |= cfg_update;
      k++;
    end
`else
    exp_k = TMO;
    while (busy !== 1'b0 && k < 4 * TMO) begin
      step();
      saw_upd |= cfg_update;
      k++;
    end
`endif
    checks++;
    if (k !== exp_k) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles expected %0d", k, exp_k);
    end
    checks++;
    if ({freq_word, saw_upd} !== {16'h1234, 1'b0}) begin
      errors++;
      $display("FAIL timeout_abort: got freq=%h upd_seen=%b expected 1234/0", freq_word, saw_upd);
    end
`ifdef WAVE_CMD_ECHO_EN
    checks++;
    if (tx_data !== 8'h3F) begin
      errors++;
      $display("FAIL timeout_nak: got txd=%h expected 3f", tx_data);
    end
    step();
`endif
    checks++;
    if ({busy, tx_valid} !== 2'b00) begin
      errors++;
      $display("FAIL timeout_idle: got busy=%b txv=%b expected 0/0", busy, tx_valid);
    end
  endtask

  task automatic test_unknown();
    send_byte(8'h78);
    checks++;
    if ({wave_sel, noise_en, cfg_update} !== {3'b010, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL unknown_cfg: got sel=%b noise=%b upd=%b expected 010/0/0", wave_sel, noise_en, cfg_update);
    end
    step();
`ifdef WAVE_CMD_ECHO_EN
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h3F}) begin
      errors++;
      $display("FAIL unknown_nak: got txv=%b txd=%h expected 1/3f", tx_valid, tx_data);
    end
    step();
`endif
    send_byte(8'h0D);
    checks++;
    if ({cfg_update, busy} !== 2'b00) begin
      errors++;
      $display("FAIL cr_ignored: got upd=%b busy=%b expected 0/0", cfg_update, busy);
    end
    step();
    step();
    checks++;
    if ({tx_valid, busy, wave_sel} !== {1'b0, 1'b0, 3'b010}) begin
      errors++;
      $display("FAIL cr_silent: got txv=%b busy=%b sel=%b expected 0/0/010", tx_valid, busy, wave_sel);
    end
  endtask

  task automatic test_back_to_back();
    tx_ready = 1'b0;
    send_byte(8'h53);
    send_byte(8'h51);
    send_byte(8'h45);
`ifdef WAVE_CMD_ECHO_EN
    checks++;
    if ({wave_sel, overrun, tx_valid, tx_data} !== {3'b011, 1'b1, 1'b1, 8'h4B}) begin
      errors++;
      $display("FAIL b2b_hold: got sel=%b ovr=%b txv=%b txd=%h expected 011/1/1/4b", wave_sel, overrun, tx_valid, tx_data);
    end
    repeat (3) step();
    checks++;
    if ({tx_valid, tx_data, wave_sel} !== {1'b1, 8'h4B, 3'b011}) begin
      errors++;
      $display("FAIL b2b_stable: got txv=%b txd=%h sel=%b expected 1/4b/011", tx_valid, tx_data, wave_sel);
    end
    tx_ready = 1'b1;
    step();
    checks++;
    if ({tx_valid, busy, wave_sel} !== {1'b0, 1'b0, 3'b011}) begin
      errors++;
      $display("FAIL b2b_handshake: got txv=%b busy=%b sel=%b expected 0/0/011", tx_valid, busy, wave_sel);
    end
    step();
    checks++;
    if ({wave_sel, cfg_update} !== {3'b010, 1'b1}) begin
      errors++;
      $display("FAIL b2b_pending: got sel=%b upd=%b expected 010/1", wave_sel, cfg_update);
    end
    step();
    checks++;
    if ({tx_valid, tx_data} !== {1'b1, 8'h4B}) begin
      errors++;
      $display("FAIL b2b_pending_ack: got txv=%b txd=%h expected 1/4b", tx_valid, tx_data);
    end
    step();
    step();
    checks++;
    if ({tx_valid, busy, wave_sel, overrun} !== {1'b0, 1'b0, 3'b010, 1'b1}) begin
      errors++;
      $display("FAIL b2b_dropped: got txv=%b busy=%b sel=%b ovr=%b expected 0/0/010/1", tx_valid, busy, wave_sel, overrun);
    end
`else
    checks++;
    if ({wave_sel, cfg_update, overrun, tx_valid} !== {3'b100, 1'b1, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL b2b_direct: got sel=%b upd=%b ovr=%b txv=%b expected 100/1/0/0", wave_sel, cfg_update, overrun, tx_valid);
    end
    tx_ready = 1'b1;
    step();
`endif
  endtask

  task automatic test_reset_mid_command();
    send_byte(8'h44);
    send_byte(8'h12);
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({freq_word, busy, overrun, tx_valid, wave_sel} !== {16'h0400, 1'b0, 1'b0, 1'b0, 3'b000}) begin
      errors++;
      $display("FAIL reset_mid: got freq=%h busy=%b ovr=%b txv=%b sel=%b expected 0400/0/0/0/000", freq_word, busy, overrun, tx_valid, wave_sel);
    end
    send_byte(8'h34);
    checks++;
    if ({freq_word, cfg_update} !== {16'h0400, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_discard: got freq=%h upd=%b expected 0400/0", freq_word, cfg_update);
    end
    repeat (3) step();
  endtask

  initial begin
    #1;
    test_reset();
    test_wave_select();
    test_noise();
    test_freq();
    test_timeout();
    test_unknown();
    test_back_to_back();
    test_reset_mid_command();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
